// File: rtl/mcdf_pkg.sv
// Shared types for the MCDF packet formatter: FSM states, channel ids,
// packet length codes and the length-code decoder.
package mcdf_pkg;

    localparam int FIFO_WIDE = 32;
    localparam int BUF_DEPTH = 32;
    localparam int BUF_AW    = 5;
    localparam int LEN_W     = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_REQ     = 3'd2,
        ST_SEND    = 3'd3,
        ST_GAP     = 3'd4
    } fmt_state_e;

    typedef enum logic [1:0] {
        CH0     = 2'b00,
        CH1     = 2'b01,
        CH2     = 2'b10,
        CH_NONE = 2'b11
    } ch_id_e;

    typedef enum logic [2:0] {
        LEN_CODE_4  = 3'd0,
        LEN_CODE_8  = 3'd1,
        LEN_CODE_16 = 3'd2,
        LEN_CODE_32 = 3'd3
    } len_code_e;

    // Codes 3..7 all select the longest packet.
    function automatic logic [LEN_W-1:0] decode_len(input logic [2:0] code);
        case (code)
            LEN_CODE_4:  decode_len = 6'd4;
            LEN_CODE_8:  decode_len = 6'd8;
            LEN_CODE_16: decode_len = 6'd16;
            default:     decode_len = 6'd32;
        endcase
    endfunction

endpackage

// File: rtl/fmt_buffer.sv
// Packet buffer for the formatter: synchronous FIFO with wrapping pointers
// and a combinational read port showing the word at the read pointer.
module fmt_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr_en)
                r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (i_rd_en)
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: pointers alone decide what is valid.
    always_ff @(posedge i_clk) begin
        if (i_wr_en)
            r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/mcdf_formatter.sv
// MCDF packet formatter: locks to one arbiter channel, buffers a packet and
// bursts it downstream with framing. Define FMT_PARITY_EN to append a parity word.
//
// state   | meaning
// IDLE    | waiting for the first word from any channel
// COLLECT | filling the buffer from the locked channel only
// REQ     | packet complete, requesting the downstream bus
// SEND    | bursting buffered words, one per cycle
// GAP     | one quiet cycle between packets
module mcdf_formatter
    import mcdf_pkg::*;
#(
    parameter int FIFO_WIDE_P = FIFO_WIDE,
    parameter int BUF_DEPTH_P = BUF_DEPTH,
    parameter int BUF_AW_P    = BUF_AW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             fmt_pkt_len,
    input  logic                   fmt_in_valid,
    input  logic [1:0]             fmt_in_chid,
    input  logic [FIFO_WIDE_P-1:0] fmt_in_data,
    output logic                   fmt_ready,
    input  logic                   fmt_grant,
    output logic                   fmt_req,
    output logic                   fmt_valid,
    output logic                   fmt_start,
    output logic                   fmt_end,
    output logic [1:0]             fmt_chid,
    output logic [FIFO_WIDE_P-1:0] fmt_data
);

    fmt_state_e             r_state;
    fmt_state_e             w_state_nxt;
    logic [LEN_W-1:0]       r_len;
    logic [LEN_W-1:0]       r_cnt;
    logic [LEN_W-1:0]       w_len_m1;
    logic [LEN_W-1:0]       w_last;
    logic [1:0]             r_lock_id;
    logic                   w_wr_en;
    logic                   w_rd_en;
    logic [FIFO_WIDE_P-1:0] w_rd_data;
`ifdef FMT_PARITY_EN
    logic [FIFO_WIDE_P-1:0] r_parity;
`endif

    assign w_len_m1 = r_len - LEN_W'(1);
`ifdef FMT_PARITY_EN
    assign w_last = r_len;
`else
    assign w_last = w_len_m1;
`endif

    fmt_buffer #(
        .WIDTH (FIFO_WIDE_P),
        .DEPTH (BUF_DEPTH_P),
        .AW    (BUF_AW_P)
    ) u_buffer (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_data (fmt_in_data),
        .i_rd_en   (w_rd_en),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        fmt_ready   = 1'b0;
        fmt_req     = 1'b0;
        fmt_valid   = 1'b0;
        fmt_start   = 1'b0;
        fmt_end     = 1'b0;
        fmt_chid    = '0;
        fmt_data    = '0;
        case (r_state)
            ST_IDLE: begin
                fmt_ready = 1'b1;
                if (fmt_in_valid && fmt_in_chid != CH_NONE) begin
                    w_wr_en     = 1'b1;
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                fmt_ready = (fmt_in_chid == r_lock_id);
                if (fmt_ready && fmt_in_valid) begin
                    w_wr_en = 1'b1;
                    if (r_cnt == w_len_m1)
                        w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                fmt_req = 1'b1;
                if (fmt_grant)
                    w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                fmt_valid = 1'b1;
                fmt_chid  = r_lock_id;
                fmt_start = (r_cnt == '0);
                fmt_end   = (r_cnt == w_last);
`ifdef FMT_PARITY_EN
                w_rd_en  = (r_cnt != r_len);
                fmt_data = (r_cnt == r_len) ? r_parity : w_rd_data;
`else
                w_rd_en  = 1'b1;
                fmt_data = w_rd_data;
`endif
                if (r_cnt == w_last)
                    w_state_nxt = ST_GAP;
            end
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        // The arbiter must see no accept strobe while the block is held in reset.
        if (!rst_n)
            fmt_ready = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len     <= '0;
            r_cnt     <= '0;
            r_lock_id <= '0;
`ifdef FMT_PARITY_EN
            r_parity  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_en) begin
                        r_lock_id <= fmt_in_chid;
                        r_len     <= decode_len(fmt_pkt_len);
                        r_cnt     <= LEN_W'(1);
`ifdef FMT_PARITY_EN
                        r_parity  <= fmt_in_data;
`endif
                    end
                end
                ST_COLLECT: begin
                    if (w_wr_en) begin
                        r_cnt    <= (r_cnt == w_len_m1) ? '0 : r_cnt + 1'b1;
`ifdef FMT_PARITY_EN
                        r_parity <= r_parity ^ fmt_in_data;
`endif
                    end
                end
                ST_SEND: r_cnt <= (r_cnt == w_last) ? '0 : r_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mcdf_formatter.sv
// Self-checking bench for mcdf_formatter: directed scenarios plus randomized
// packets checked against a packet-level reference model.
module tb_mcdf_formatter;
    import mcdf_pkg::*;

`ifdef FMT_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  chid;
        logic [31:0] data;
        logic        s;
        logic        e;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  fmt_pkt_len = '0;
    logic        fmt_in_valid = 1'b0;
    logic [1:0]  fmt_in_chid = 2'b11;
    logic [31:0] fmt_in_data = '0;
    logic        fmt_ready;
    logic        fmt_grant = 1'b0;
    logic        fmt_req;
    logic        fmt_valid;
    logic        fmt_start;
    logic        fmt_end;
    logic [1:0]  fmt_chid;
    logic [31:0] fmt_data;

    obs_t        obs_q[$];
    obs_t        exp_q[$];
    logic [31:0] words[$];
    int errors = 0, checks = 0;
    int req_cnt = 0, zero_viol = 0, overlap = 0;

    always #5 clk = ~clk;

    mcdf_formatter dut (
        .clk(clk), .rst_n(rst_n), .fmt_pkt_len(fmt_pkt_len),
        .fmt_in_valid(fmt_in_valid), .fmt_in_chid(fmt_in_chid), .fmt_in_data(fmt_in_data),
        .fmt_ready(fmt_ready), .fmt_grant(fmt_grant), .fmt_req(fmt_req),
        .fmt_valid(fmt_valid), .fmt_start(fmt_start), .fmt_end(fmt_end),
        .fmt_chid(fmt_chid), .fmt_data(fmt_data)
    );

    always @(negedge clk) begin
        if (fmt_valid) obs_q.push_back(obs_t'({fmt_chid, fmt_data, fmt_start, fmt_end}));
        if (fmt_req) req_cnt++;
        if (!fmt_valid && (fmt_data !== '0 || fmt_chid !== '0 || fmt_start !== 1'b0 || fmt_end !== 1'b0))
            zero_viol++;
        if (fmt_valid && fmt_req) overlap++;
    end

    function automatic int dec_len(input int code);
        if (code == 0) return 4;
        if (code == 1) return 8;
        if (code == 2) return 16;
        return 32;
    endfunction

    // Expected burst: the first len accepted words, framed, plus optional XOR word.
    function automatic void build_exp(input logic [1:0] ch, input int len);
        logic [31:0] x;
        x = '0;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(obs_t'({ch, words[i], (i == 0), (i == len - 1) && !PAR}));
            x ^= words[i];
        end
        if (PAR) exp_q.push_back(obs_t'({ch, x, 1'b0, 1'b1}));
    endfunction

    function automatic void fill_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endfunction

    // Presents words[] on channel ch; after intr_at accepts, shows intr_ch for
    // intr_len cycles (must be refused) and switches the length code.
    task automatic drive_pkt(input logic [1:0] ch, input int code, input int intr_at,
                             input int intr_len, input logic [1:0] intr_ch,
                             input int code_after, input int gp, output int rdy_err);
        int i = 0, k = 0, cyc = 0;
        bit is_int;
        rdy_err = 0;
        fmt_pkt_len = 3'(code);
        while (i < words.size() && cyc < 300) begin
            is_int = (i == intr_at) && (k < intr_len);
            if (i == intr_at) fmt_pkt_len = 3'(code_after);
            fmt_in_valid = 1'b1;
            fmt_in_chid  = is_int ? intr_ch : ch;
            fmt_in_data  = is_int ? $urandom : words[i];
            if (gp >= 0) fmt_grant = (i == gp);
            @(negedge clk);
            if (fmt_ready !== !is_int) rdy_err++;
            if (is_int) k++;
            else if (fmt_ready) i++;
            @(posedge clk); #2;
            cyc++;
        end
        if (i < words.size()) rdy_err++;
        fmt_in_valid = 1'b0;
        fmt_in_chid  = 2'b11;
        fmt_in_data  = '0;
        if (gp >= 0) fmt_grant = 1'b0;
    endtask

    task automatic wait_burst(input int n, output bit to);
        int cyc = 0;
        to = 1'b1;
        while (cyc < 400) begin
            @(negedge clk);
            if (obs_q.size() >= n && !fmt_valid) begin
                to = 1'b0;
                break;
            end
            cyc++;
        end
        @(posedge clk); #2;
    endtask

    task automatic test_reset();
        fmt_in_valid = 1'b1;
        fmt_in_chid  = 2'b01;
        #3;
        checks++;
        if ({fmt_ready, fmt_req, fmt_valid, fmt_start, fmt_end, fmt_chid, fmt_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {fmt_ready, fmt_req, fmt_valid, fmt_start, fmt_end, fmt_chid, fmt_data});
        end
        fmt_in_valid = 1'b0;
        fmt_in_chid  = 2'b11;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({fmt_ready, fmt_req} !== 2'b10) begin
            errors++;
            $display("FAIL idle_ready_req got=%b exp=10", {fmt_ready, fmt_req});
        end
        @(posedge clk); #2;
    endtask

    task automatic test_basic();
        int re; bit to;
        words = '{32'h11, 32'h12, 32'h13, 32'h14};
        fmt_grant = 1'b1;
        obs_q.delete();
        build_exp(2'd1, 4);
        drive_pkt(2'd1, 0, -1, 0, 2'd0, 0, -1, re);
        checks++;
        if (re !== 0) begin errors++; $display("FAIL t1_ready got=%0d errs exp=0", re); end
        @(negedge clk);
        checks++;
        if ({fmt_req, fmt_valid} !== 2'b10) begin
            errors++; $display("FAIL t1_req_timing got=%b exp=10", {fmt_req, fmt_valid});
        end
        @(negedge clk);
        checks++;
        if ({fmt_req, fmt_valid, fmt_start} !== 3'b011) begin
            errors++; $display("FAIL t1_first_word got=%b exp=011", {fmt_req, fmt_valid, fmt_start});
        end
        wait_burst(exp_q.size(), to);
        checks++;
        if (to || obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL t1_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL t1_word%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_priority();
        int re; bit to;
        fill_words(32);
        fmt_grant = 1'b1;
        obs_q.delete();
        build_exp(2'd0, 32);
        drive_pkt(2'd0, 3, 10, 5, 2'd2, 3, -1, re);
        checks++;
        if (re !== 0) begin errors++; $display("FAIL t2_ready got=%0d errs exp=0", re); end
        wait_burst(exp_q.size(), to);
        checks++;
        if (to || obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL t2_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL t2_word%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_grant_delay();
        int re; bit to;
        fmt_grant = 1'b0;
        obs_q.delete();
        req_cnt = 0;
        repeat (3) begin
            fmt_grant = 1'b1;
            @(posedge clk); #2;
        end
        fmt_grant = 1'b0;
        checks++;
        if (obs_q.size() != 0 || req_cnt != 0) begin
            errors++; $display("FAIL t3_idle_grant got=%0d/%0d exp=0/0", obs_q.size(), req_cnt);
        end
        fill_words(8);
        build_exp(2'd2, 8);
        drive_pkt(2'd2, 1, -1, 0, 2'd0, 1, 3, re);
        checks++;
        if (re !== 0) begin errors++; $display("FAIL t3_ready got=%0d errs exp=0", re); end
        // Grant arrives during the 7th request cycle.
        repeat (6) begin @(posedge clk); #2; end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL t3_early_output got=%0d exp=0", obs_q.size());
        end
        fmt_grant = 1'b1;
        wait_burst(exp_q.size(), to);
        fmt_grant = 1'b0;
        checks++;
        if (req_cnt != 7) begin errors++; $display("FAIL t3_req_cycles got=%0d exp=7", req_cnt); end
        checks++;
        if (to || obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL t3_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL t3_word%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int re; bit to;
        fmt_grant = 1'b0;
        obs_q.delete();
        fill_words(6);
        drive_pkt(2'd0, 2, -1, 0, 2'd0, 2, -1, re);
        checks++;
        if (re !== 0) begin errors++; $display("FAIL t4_ready got=%0d errs exp=0", re); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({fmt_ready, fmt_req, fmt_valid, fmt_start, fmt_end, fmt_chid, fmt_data} !== '0) begin
            errors++;
            $display("FAIL t4_async_reset got=%h exp=0",
                     {fmt_ready, fmt_req, fmt_valid, fmt_start, fmt_end, fmt_chid, fmt_data});
        end
        repeat (2) begin @(posedge clk); #2; end
        rst_n = 1'b1;
        fill_words(4);
        fmt_grant = 1'b1;
        build_exp(2'd1, 4);
        drive_pkt(2'd1, 0, -1, 0, 2'd0, 0, -1, re);
        wait_burst(exp_q.size(), to);
        checks++;
        if (to || obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL t4_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL t4_word%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_len_change();
        int re; bit to;
        fmt_grant = 1'b1;
        for (int p = 0; p < 2; p++) begin
            obs_q.delete();
            fill_words(p == 0 ? 8 : 16);
            build_exp(2'd2, p == 0 ? 8 : 16);
            if (p == 0) drive_pkt(2'd2, 1, 3, 0, 2'd0, 2, -1, re);
            else        drive_pkt(2'd2, 2, -1, 0, 2'd0, 2, -1, re);
            wait_burst(exp_q.size(), to);
            checks++;
            if (re !== 0 || to || obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL t5_pkt%0d_len got=%0d exp=%0d rdy_errs=%0d", p, obs_q.size(), exp_q.size(), re);
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL t5_pkt%0d_word%0d got=%h exp=%h", p, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_parity();
        int re; bit to;
        logic [31:0] exp_last;
        exp_last = PAR ? 32'hF : 32'h8;
        words = '{32'h1, 32'h2, 32'h4, 32'h8};
        fmt_grant = 1'b1;
        obs_q.delete();
        build_exp(2'd0, 4);
        drive_pkt(2'd0, 0, -1, 0, 2'd0, 0, -1, re);
        wait_burst(exp_q.size(), to);
        checks++;
        if (to || obs_q.size() != (PAR ? 5 : 4)) begin
            errors++; $display("FAIL t6_count got=%0d exp=%0d", obs_q.size(), PAR ? 5 : 4);
        end
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[obs_q.size()-1].data !== exp_last || obs_q[obs_q.size()-1].e !== 1'b1) begin
                errors++;
                $display("FAIL t6_last got=%h end=%b exp=%h end=1",
                         obs_q[obs_q.size()-1].data, obs_q[obs_q.size()-1].e, exp_last);
            end
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL t6_word%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int re, code, len, ia, il, gd;
        logic [1:0] ch, ich;
        bit to;
        for (int p = 0; p < 8; p++) begin
            ch   = 2'($urandom_range(0, 2));
            code = $urandom_range(0, 7);
            len  = dec_len(code);
            ia   = $urandom_range(1, len - 1);
            il   = $urandom_range(0, 4);
            ich  = 2'((int'(ch) + $urandom_range(1, 3)) % 4);
            gd   = $urandom_range(0, 3);
            fill_words(len);
            build_exp(ch, len);
            fmt_grant = 1'b0;
            obs_q.delete();
            drive_pkt(ch, code, ia, il, ich, code, -1, re);
            repeat (gd) begin @(posedge clk); #2; end
            fmt_grant = 1'b1;
            wait_burst(exp_q.size(), to);
            fmt_grant = 1'b0;
            checks++;
            if (re !== 0 || to || obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rnd%0d_len got=%0d exp=%0d rdy_errs=%0d", p, obs_q.size(), exp_q.size(), re);
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL rnd%0d_word%0d got=%h exp=%h", p, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_idle_outputs();
        checks++;
        if (zero_viol != 0) begin
            errors++; $display("FAIL idle_outputs_zero got=%0d cycles exp=0", zero_viol);
        end
        checks++;
        if (overlap != 0) begin
            errors++; $display("FAIL req_during_send got=%0d cycles exp=0", overlap);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_grant_delay();
        test_reset_mid();
        test_len_change();
        test_parity();
        test_random();
        test_idle_outputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
